// File: rtl/reg_file_ras.sv
// reg_file_ras: 16-entry CPU register file with PC/link logic, GPI receive FIFO and
// a return-address stack. Define RAS_EN to build the RAS and enable RET; otherwise RET is pc+1.
module reg_file_ras #(
   parameter int DATA_W    = 8,
   parameter int RAS_DEPTH = 4,
   parameter int GPI_DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [DATA_W-1:0]            alu_out,
   input  logic                         E_out,
   input  logic [3:0]                   opcode,
   input  logic [3:0]                   raddr1,
   input  logic [3:0]                   raddr2,
   input  logic [3:0]                   waddr,
   input  logic [DATA_W-1:0]            gpi,
   input  logic                         gpi_we,
   input  logic [DATA_W-1:0]            dmem_out,
   input  logic [3:0]                   SW,
   output logic [DATA_W-1:0]            a,
   output logic [DATA_W-1:0]            b,
   output logic                         E,
   output logic                         F,
   output logic [DATA_W-1:0]            pc,
   output logic [DATA_W-1:0]            gpo,
   output logic [2*DATA_W-1:0]          mem_addr,
   output logic                         dmem_we,
   output logic                         vmem_we,
   output logic [$clog2(GPI_DEPTH):0]   gpi_count,
   output logic                         gpi_ovf,
   output logic                         ras_ovf,
   output logic                         ras_unf
);

   localparam int GPI_AW = $clog2(GPI_DEPTH);
   localparam int GPI_CW = GPI_AW + 1;

   localparam logic [3:0] OP_LDI  = 4'b1100;
   localparam logic [3:0] OP_DMR  = 4'b1101;
   localparam logic [3:0] OP_JMP  = 4'b1110;
   localparam logic [3:0] OP_SYS  = 4'b1111;
   localparam logic [3:0] SUB_CLF = 4'b0001;
   localparam logic [3:0] SUB_CLE = 4'b0010;
   localparam logic [3:0] SUB_RET = 4'b0011;
   localparam logic [3:0] SUB_VWE = 4'b0100;
   localparam logic [3:0] SUB_DWE = 4'b1000;

   logic [DATA_W-1:0] regs [0:12];
   logic [DATA_W-1:0] r14_q;
   logic [DATA_W-1:0] pc_q;
   logic              e_q;

   logic [DATA_W-1:0] gpi_mem [0:GPI_DEPTH-1];
   logic [GPI_AW-1:0] gpi_rd_ptr, gpi_wr_ptr;
   logic [GPI_CW-1:0] gpi_count_q;
   logic              gpi_ovf_q;

   logic [DATA_W-1:0] rf_view [0:15];
   logic [DATA_W-1:0] gpi_head;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] pc_inc;
   logic [DATA_W-1:0] pc_next;
   logic              normal_op, is_call, is_ret, is_clf, is_cle;
   logic              gpi_empty, gpi_full, push_ok, pop_ok;
   logic              jump_unsat;
   logic              ras_hit;
   logic [DATA_W-1:0] ras_top_val;

   assign normal_op = (opcode[3:1] != 3'b111);
   assign is_call   = normal_op && (waddr == 4'd15);
   assign is_ret    = (opcode == OP_SYS) && (waddr == SUB_RET);
   assign is_clf    = (opcode == OP_SYS) && (waddr == SUB_CLF);
   assign is_cle    = (opcode == OP_SYS) && (waddr == SUB_CLE);
   assign vmem_we   = (opcode == OP_SYS) && (waddr == SUB_VWE);
   assign dmem_we   = (opcode == OP_SYS) && (waddr == SUB_DWE);

   assign gpi_empty = (gpi_count_q == '0);
   assign gpi_full  = (gpi_count_q == GPI_CW'(GPI_DEPTH));
   assign gpi_head  = gpi_empty ? '0 : gpi_mem[gpi_rd_ptr];
   // A push into a full FIFO only succeeds when the same cycle frees a slot.
   assign pop_ok    = is_clf && !gpi_empty;
   assign push_ok   = gpi_we && (!gpi_full || pop_ok);

   always_comb begin
      for (int i = 0; i < 13; i++) rf_view[i] = regs[i];
      rf_view[13] = gpi_head;
      rf_view[14] = r14_q;
      rf_view[15] = pc_q;
   end

   assign a        = rf_view[raddr1];
   assign b        = rf_view[raddr2];
   assign gpo      = rf_view[SW];
   assign mem_addr = {regs[11], regs[10]};
   assign pc       = pc_q;
   assign E        = e_q;
   assign F        = !gpi_empty;
   assign gpi_count = gpi_count_q;
   assign gpi_ovf  = gpi_ovf_q;
   assign pc_inc   = pc_q + DATA_W'(1);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      wdata = alu_out;
      if (opcode == OP_LDI)      wdata = DATA_W'({raddr1, raddr2});
      else if (opcode == OP_DMR) wdata = dmem_out;
   end

   always_comb begin
      jump_unsat = 1'b0;
      if (opcode == OP_JMP) begin
         case (waddr)
            4'b0001: jump_unsat = (a != b);
            4'b0010: jump_unsat = !(a > b);
            4'b0100: jump_unsat = gpi_empty;
            4'b1000: jump_unsat = !e_q;
            default: jump_unsat = 1'b0;
         endcase
      end
   end

   always_comb begin
      pc_next = pc_inc;
      if (is_call)                pc_next = wdata;
      else if (is_ret && ras_hit) pc_next = ras_top_val;
      else if (jump_unsat)        pc_next = pc_q + DATA_W'(2);
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 13; i++) regs[i] <= '0;
         r14_q       <= '0;
         pc_q        <= '0;
         e_q         <= 1'b0;
         gpi_rd_ptr  <= '0;
         gpi_wr_ptr  <= '0;
         gpi_count_q <= '0;
         gpi_ovf_q   <= 1'b0;
      end else begin
         pc_q <= pc_next;
         if (normal_op && (waddr < 4'd13)) regs[waddr] <= wdata;
         if (is_call) r14_q <= pc_inc;
         e_q <= is_cle ? 1'b0 : E_out;
         if (push_ok) gpi_wr_ptr <= gpi_wr_ptr + GPI_AW'(1);
         if (pop_ok)  gpi_rd_ptr <= gpi_rd_ptr + GPI_AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   gpi_count_q <= gpi_count_q + GPI_CW'(1);
            2'b01:   gpi_count_q <= gpi_count_q - GPI_CW'(1);
            default: gpi_count_q <= gpi_count_q;
         endcase
         if (gpi_we && !push_ok) gpi_ovf_q <= 1'b1;
      end
   end

   // NOTE: FIFO storage is not reset; the pointers and count alone define its contents.
   always_ff @(posedge clock) begin
      if (push_ok) gpi_mem[gpi_wr_ptr] <= gpi;
   end

`ifdef RAS_EN
   localparam int RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int RAS_CW = $clog2(RAS_DEPTH + 1);

   logic [DATA_W-1:0] ras_mem [0:RAS_DEPTH-1];
   logic [RAS_AW-1:0] ras_top, ras_top_up, ras_top_dn;
   logic [RAS_CW-1:0] ras_cnt;
   logic              ras_full, ras_ovf_q, ras_unf_q;

   assign ras_full    = (ras_cnt == RAS_CW'(RAS_DEPTH));
   assign ras_hit     = (ras_cnt != '0);
   assign ras_top_val = ras_mem[ras_top];
   assign ras_top_up  = (ras_top == RAS_AW'(RAS_DEPTH - 1)) ? '0 : ras_top + RAS_AW'(1);
   assign ras_top_dn  = (ras_top == '0) ? RAS_AW'(RAS_DEPTH - 1) : ras_top - RAS_AW'(1);
   assign ras_ovf     = ras_ovf_q;
   assign ras_unf     = ras_unf_q;

   // Circular stack: a push onto a full stack lands on the oldest slot.
   always_ff @(posedge clock) begin
      if (reset) begin
         ras_top   <= '0;
         ras_cnt   <= '0;
         ras_ovf_q <= 1'b0;
         ras_unf_q <= 1'b0;
      end else if (is_call) begin
         ras_top <= ras_top_up;
         if (ras_full) ras_ovf_q <= 1'b1;
         else          ras_cnt   <= ras_cnt + RAS_CW'(1);
      end else if (is_ret) begin
         if (ras_hit) begin
            ras_top <= ras_top_dn;
            ras_cnt <= ras_cnt - RAS_CW'(1);
         end else begin
            ras_unf_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (is_call) ras_mem[ras_top_up] <= pc_inc;
   end
`else
   assign ras_hit     = 1'b0;
   assign ras_top_val = '0;
   assign ras_ovf     = 1'b0;
   assign ras_unf     = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_ras.sv
// Directed bench for reg_file_ras: stimulus queues expected values, a negedge monitor
// pops and compares them. Expectations follow RAS_EN if the macro is defined.
module tb_reg_file_ras;

`ifdef RAS_EN
   localparam bit RAS = 1'b1;
`else
   localparam bit RAS = 1'b0;
`endif

   typedef enum int {K_PC, K_A, K_B, K_E, K_F, K_CNT, K_GOVF, K_ROVF, K_RUNF,
                     K_GPO, K_MADDR, K_DWE, K_VWE} kind_t;

   typedef struct {
      int          due;
      kind_t       kind;
      logic [15:0] expv;
      string       name;
   } item_t;

   logic        clock, reset;
   logic [7:0]  alu_out, gpi, dmem_out;
   logic        E_out, gpi_we;
   logic [3:0]  opcode, raddr1, raddr2, waddr, SW;
   logic [7:0]  a, b, pc, gpo;
   logic        E, F, dmem_we, vmem_we, gpi_ovf, ras_ovf, ras_unf;
   logic [15:0] mem_addr;
   logic [2:0]  gpi_count;

   item_t sb[$];
   int    cyc = 0;
   int    checks = 0;
   int    failures = 0;

   reg_file_ras dut (
      .clock(clock), .reset(reset), .alu_out(alu_out), .E_out(E_out),
      .opcode(opcode), .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr),
      .gpi(gpi), .gpi_we(gpi_we), .dmem_out(dmem_out), .SW(SW),
      .a(a), .b(b), .E(E), .F(F), .pc(pc), .gpo(gpo), .mem_addr(mem_addr),
      .dmem_we(dmem_we), .vmem_we(vmem_we), .gpi_count(gpi_count),
      .gpi_ovf(gpi_ovf), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [15:0] sample(input kind_t k);
      case (k)
         K_PC:    return {8'h00, pc};
         K_A:     return {8'h00, a};
         K_B:     return {8'h00, b};
         K_E:     return {15'h0, E};
         K_F:     return {15'h0, F};
         K_CNT:   return {13'h0, gpi_count};
         K_GOVF:  return {15'h0, gpi_ovf};
         K_ROVF:  return {15'h0, ras_ovf};
         K_RUNF:  return {15'h0, ras_unf};
         K_GPO:   return {8'h00, gpo};
         K_MADDR: return mem_addr;
         K_DWE:   return {15'h0, dmem_we};
         K_VWE:   return {15'h0, vmem_we};
         default: return 16'hxxxx;
      endcase
   endfunction

   // Monitor: compares every expectation due in the current cycle, away from the clock edge.
   always @(negedge clock) begin
      while (sb.size() != 0 && sb[0].due <= cyc) begin
         item_t it;
         logic [15:0] act;
         it  = sb.pop_front();
         act = sample(it.kind);
         checks++;
         if (it.due != cyc) begin
            failures++;
            $display("FAIL %s: stale expectation due cycle %0d, now %0d", it.name, it.due, cyc);
         end else if (act !== it.expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", it.name, act, it.expv, cyc);
         end
      end
   end

   task automatic exp_now(input kind_t k, input logic [15:0] v, input string n);
      item_t it;
      it.due  = cyc;
      it.kind = k;
      it.expv = v;
      it.name = n;
      sb.push_back(it);
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] r1, input logic [3:0] r2,
                        input logic [3:0] wa, input logic [7:0] alu);
      @(posedge clock);
      #1;
      opcode  = op;
      raddr1  = r1;
      raddr2  = r2;
      waddr   = wa;
      alu_out = alu;
      gpi_we  = 1'b0;
   endtask

   task automatic push_nop(input logic [7:0] data);
      drive(4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
      gpi    = data;
      gpi_we = 1'b1;
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      reset  = 1'b1;
      opcode = 4'h0; raddr1 = 4'h0; raddr2 = 4'h0; waddr = 4'h0;
      alu_out = 8'h00; gpi_we = 1'b0; E_out = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; opcode = 4'h0; raddr1 = 4'h0; raddr2 = 4'h0; waddr = 4'h0;
      alu_out = 8'h00; gpi = 8'h00; gpi_we = 1'b0; E_out = 1'b0;
      dmem_out = 8'h00; SW = 4'h0;
      do_reset();

      // ---- sequencing, call/RET, jumps, E, strobes ----
      alu_out = 8'h11;
      exp_now(K_PC, 16'h0, "rst_pc");      exp_now(K_E, 16'h0, "rst_e");
      exp_now(K_F, 16'h0, "rst_f");        exp_now(K_CNT, 16'h0, "rst_cnt");
      exp_now(K_GOVF, 16'h0, "rst_govf");  exp_now(K_ROVF, 16'h0, "rst_rovf");
      exp_now(K_RUNF, 16'h0, "rst_runf");
      drive(4'h0, 4'h0, 4'h0, 4'h0, 8'h22); exp_now(K_PC, 16'h1, "seq_pc1"); exp_now(K_A, 16'h11, "r0_a");
      drive(4'h0, 4'h0, 4'h0, 4'h0, 8'h33); exp_now(K_PC, 16'h2, "seq_pc2"); exp_now(K_A, 16'h22, "r0_b");
      drive(4'h0, 4'h0, 4'h0, 4'h0, 8'h44); exp_now(K_PC, 16'h3, "seq_pc3"); exp_now(K_A, 16'h33, "r0_c");
      drive(4'h0, 4'h0, 4'h0, 4'h0, 8'h55); exp_now(K_PC, 16'h4, "seq_pc4"); exp_now(K_A, 16'h44, "r0_d");
      drive(4'hC, 4'h4, 4'h0, 4'hF, 8'h00); exp_now(K_PC, 16'h5, "seq_pc5");
      drive(4'hF, 4'hE, 4'hF, 4'h3, 8'h00);
      exp_now(K_PC, 16'h40, "call_pc"); exp_now(K_A, 16'h06, "call_r14"); exp_now(K_B, 16'h40, "r15_read");
      drive(4'hC, 4'h0, 4'h3, 4'h1, 8'h00);
      exp_now(K_PC, RAS ? 16'h06 : 16'h41, "ret_pc"); exp_now(K_RUNF, 16'h0, "ret_no_unf");
      drive(4'hC, 4'h0, 4'h4, 4'h2, 8'h00);
      drive(4'hC, 4'h8, 4'h0, 4'h3, 8'h00);
      drive(4'hC, 4'h7, 4'hF, 4'h4, 8'h00);
      drive(4'hC, 4'h0, 4'hA, 4'hF, 8'h00);
      drive(4'hE, 4'h1, 4'h1, 4'h1, 8'h00);
      exp_now(K_PC, 16'h0A, "ldi_pc10"); exp_now(K_A, 16'h03, "jeq_a"); exp_now(K_B, 16'h03, "jeq_b");
      drive(4'hE, 4'h1, 4'h2, 4'h1, 8'h00);
      exp_now(K_PC, 16'h0B, "jeq_taken"); exp_now(K_B, 16'h04, "jeq_b4");
      drive(4'hC, 4'h1, 4'h4, 4'hF, 8'h00); exp_now(K_PC, 16'h0D, "jeq_skip");
      drive(4'hE, 4'h3, 4'h4, 4'h2, 8'h00);
      exp_now(K_PC, 16'h14, "ldi_pc20"); exp_now(K_A, 16'h80, "jgt_a"); exp_now(K_B, 16'h7F, "jgt_b");
      drive(4'hE, 4'h4, 4'h3, 4'h2, 8'h00); exp_now(K_PC, 16'h15, "jgt_taken");
      drive(4'hE, 4'h0, 4'h0, 4'h8, 8'h00); E_out = 1'b1;
      exp_now(K_PC, 16'h17, "jgt_skip"); exp_now(K_E, 16'h0, "e_low");
      drive(4'hE, 4'h0, 4'h0, 4'h8, 8'h00);
      exp_now(K_PC, 16'h19, "jes_skip"); exp_now(K_E, 16'h1, "e_high");
      drive(4'hF, 4'h0, 4'h0, 4'h2, 8'h00);
      exp_now(K_PC, 16'h1A, "jes_taken"); exp_now(K_E, 16'h1, "e_hold");
      drive(4'hE, 4'h0, 4'h0, 4'h4, 8'h00); E_out = 1'b0;
      exp_now(K_PC, 16'h1B, "cle_pc"); exp_now(K_E, 16'h0, "cle_clears");
      drive(4'hF, 4'h0, 4'h0, 4'h4, 8'h00);
      exp_now(K_PC, 16'h1D, "jfs_skip"); exp_now(K_VWE, 16'h1, "vwe_on"); exp_now(K_DWE, 16'h0, "dwe_off");
      drive(4'hF, 4'h0, 4'h0, 4'h8, 8'h00);
      exp_now(K_PC, 16'h1E, "vwe_pc"); exp_now(K_DWE, 16'h1, "dwe_on"); exp_now(K_VWE, 16'h0, "vwe_off");
      drive(4'hD, 4'h0, 4'h0, 4'h5, 8'h00); dmem_out = 8'h5A; exp_now(K_PC, 16'h1F, "dwe_pc");
      drive(4'h0, 4'h5, 4'h0, 4'h0, 8'h00); SW = 4'h5;
      exp_now(K_PC, 16'h20, "dmr_pc"); exp_now(K_A, 16'h5A, "dmr_r5"); exp_now(K_GPO, 16'h5A, "gpo_r5");
      drive(4'hC, 4'h3, 4'h4, 4'hA, 8'h00); exp_now(K_PC, 16'h21, "ldi_r10_pc");
      drive(4'hC, 4'h1, 4'h2, 4'hB, 8'h00); exp_now(K_PC, 16'h22, "ldi_r11_pc");
      drive(4'hE, 4'h0, 4'h0, 4'h6, 8'h00);
      exp_now(K_PC, 16'h23, "maddr_pc"); exp_now(K_MADDR, 16'h1234, "mem_addr");
      drive(4'hC, 4'h7, 4'h7, 4'hE, 8'h00); exp_now(K_PC, 16'h24, "other_subop");
      drive(4'h0, 4'hE, 4'h0, 4'h0, 8'h00);
      exp_now(K_PC, 16'h25, "ldi_r14_pc"); exp_now(K_A, 16'h0E, "r14_not_written");

      // ---- GPI FIFO ----
      do_reset();
      exp_now(K_PC, 16'h0, "g_rst_pc"); exp_now(K_F, 16'h0, "g_rst_f"); exp_now(K_CNT, 16'h0, "g_rst_cnt");
      push_nop(8'h41); exp_now(K_PC, 16'h1, "g_pc1");
      push_nop(8'h42); exp_now(K_CNT, 16'h1, "g_cnt1"); exp_now(K_F, 16'h1, "g_f1");
      drive(4'h0, 4'hD, 4'h0, 4'h0, 8'h00); SW = 4'hD;
      exp_now(K_A, 16'h41, "g_head41"); exp_now(K_CNT, 16'h2, "g_cnt2"); exp_now(K_GPO, 16'h41, "g_gpo41");
      drive(4'hF, 4'hD, 4'h0, 4'h1, 8'h00); exp_now(K_A, 16'h41, "g_clf1_head");
      drive(4'h0, 4'hD, 4'h0, 4'h0, 8'h00); exp_now(K_A, 16'h42, "g_head42"); exp_now(K_CNT, 16'h1, "g_cnt_pop");
      drive(4'hF, 4'hD, 4'h0, 4'h1, 8'h00); exp_now(K_A, 16'h42, "g_clf2_head");
      drive(4'h0, 4'hD, 4'h0, 4'h0, 8'h00);
      exp_now(K_A, 16'h0, "g_empty_r13"); exp_now(K_F, 16'h0, "g_empty_f"); exp_now(K_CNT, 16'h0, "g_empty_cnt");
      drive(4'hF, 4'hD, 4'h0, 4'h1, 8'h00); exp_now(K_A, 16'h0, "g_pop_empty_r13");
      push_nop(8'h51); exp_now(K_CNT, 16'h0, "g_pop_empty_cnt");
      push_nop(8'h52); exp_now(K_CNT, 16'h1, "g_fill1");
      push_nop(8'h53); exp_now(K_CNT, 16'h2, "g_fill2");
      push_nop(8'h54); exp_now(K_CNT, 16'h3, "g_fill3");
      push_nop(8'h55); exp_now(K_CNT, 16'h4, "g_fill4"); exp_now(K_GOVF, 16'h0, "g_no_ovf_yet");
      drive(4'hE, 4'hD, 4'h0, 4'h4, 8'h00);
      exp_now(K_CNT, 16'h4, "g_full_cnt"); exp_now(K_GOVF, 16'h1, "g_ovf"); exp_now(K_F, 16'h1, "g_full_f");
      exp_now(K_A, 16'h51, "g_full_head"); exp_now(K_PC, 16'd14, "g_jfs_pc");
      drive(4'hF, 4'hD, 4'h0, 4'h1, 8'h00); gpi = 8'h66; gpi_we = 1'b1;
      exp_now(K_PC, 16'd15, "g_jfs_taken"); exp_now(K_A, 16'h51, "g_pp_head"); exp_now(K_CNT, 16'h4, "g_pp_cnt_pre");
      drive(4'h0, 4'hD, 4'h0, 4'h0, 8'h00);
      exp_now(K_A, 16'h52, "g_pp_head2"); exp_now(K_CNT, 16'h4, "g_pp_cnt"); exp_now(K_GOVF, 16'h1, "g_ovf_sticky");
      drive(4'hF, 4'hD, 4'h0, 4'h1, 8'h00); exp_now(K_A, 16'h52, "g_drain52");
      drive(4'hF, 4'hD, 4'h0, 4'h1, 8'h00); exp_now(K_A, 16'h53, "g_drain53");
      drive(4'hF, 4'hD, 4'h0, 4'h1, 8'h00); exp_now(K_A, 16'h54, "g_drain54");
      drive(4'h0, 4'hD, 4'h0, 4'h0, 8'h00); exp_now(K_A, 16'h66, "g_fifth_lost"); exp_now(K_CNT, 16'h1, "g_cnt_last");
      drive(4'hF, 4'hD, 4'h0, 4'h1, 8'h00); exp_now(K_A, 16'h66, "g_drain66");
      drive(4'hF, 4'hD, 4'h0, 4'h1, 8'h00); gpi = 8'h77; gpi_we = 1'b1;
      exp_now(K_CNT, 16'h0, "g_pe_cnt_pre"); exp_now(K_F, 16'h0, "g_pe_f_pre");
      drive(4'h0, 4'hD, 4'h0, 4'h0, 8'h00);
      exp_now(K_A, 16'h77, "g_pe_push_only"); exp_now(K_CNT, 16'h1, "g_pe_cnt");

      // ---- return-address stack ----
      do_reset();
      exp_now(K_PC, 16'h0, "r_rst_pc"); exp_now(K_GOVF, 16'h0, "r_rst_govf");
      exp_now(K_ROVF, 16'h0, "r_rst_rovf"); exp_now(K_CNT, 16'h0, "r_rst_cnt");
      drive(4'hC, 4'h0, 4'h3, 4'hF, 8'h00); exp_now(K_PC, 16'h1, "r_pc1");
      drive(4'hC, 4'h0, 4'h5, 4'hF, 8'h00); exp_now(K_PC, 16'h3, "r_pc3");
      drive(4'hC, 4'h0, 4'h7, 4'hF, 8'h00); exp_now(K_PC, 16'h5, "r_pc5");
      drive(4'hC, 4'h0, 4'h9, 4'hF, 8'h00); exp_now(K_PC, 16'h7, "r_pc7"); exp_now(K_ROVF, 16'h0, "r_no_ovf3");
      drive(4'hC, 4'h2, 4'h0, 4'hF, 8'h00); exp_now(K_PC, 16'h9, "r_pc9"); exp_now(K_ROVF, 16'h0, "r_no_ovf4");
      drive(4'hF, 4'hE, 4'h0, 4'h3, 8'h00);
      exp_now(K_PC, 16'h20, "r_pc20"); exp_now(K_A, 16'h0A, "r_r14"); exp_now(K_ROVF, RAS ? 16'h1 : 16'h0, "r_ovf");
      drive(4'hF, 4'h0, 4'h0, 4'h3, 8'h00); exp_now(K_PC, RAS ? 16'h0A : 16'h21, "r_ret1");
      drive(4'hF, 4'h0, 4'h0, 4'h3, 8'h00); exp_now(K_PC, RAS ? 16'h08 : 16'h22, "r_ret2");
      drive(4'hF, 4'h0, 4'h0, 4'h3, 8'h00); exp_now(K_PC, RAS ? 16'h06 : 16'h23, "r_ret3");
      drive(4'hF, 4'h0, 4'h0, 4'h3, 8'h00);
      exp_now(K_PC, RAS ? 16'h04 : 16'h24, "r_ret4"); exp_now(K_RUNF, 16'h0, "r_no_unf");
      push_nop(8'h99);
      exp_now(K_PC, RAS ? 16'h05 : 16'h25, "r_ret5"); exp_now(K_RUNF, RAS ? 16'h1 : 16'h0, "r_unf");
      drive(4'hC, 4'h3, 4'h0, 4'hF, 8'h00); gpi = 8'h98; gpi_we = 1'b1; E_out = 1'b1;
      exp_now(K_CNT, 16'h1, "r_fill_cnt1");
      drive(4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
      exp_now(K_PC, 16'h30, "r_fill_pc"); exp_now(K_E, 16'h1, "r_fill_e"); exp_now(K_CNT, 16'h2, "r_fill_cnt2");
      do_reset();
      exp_now(K_PC, 16'h0, "x_rst_pc"); exp_now(K_F, 16'h0, "x_rst_f"); exp_now(K_CNT, 16'h0, "x_rst_cnt");
      exp_now(K_E, 16'h0, "x_rst_e"); exp_now(K_ROVF, 16'h0, "x_rst_rovf"); exp_now(K_RUNF, 16'h0, "x_rst_runf");
      drive(4'hF, 4'hD, 4'h0, 4'h3, 8'h00);
      exp_now(K_PC, 16'h1, "x_ret_pc"); exp_now(K_A, 16'h0, "x_r13_empty"); exp_now(K_RUNF, 16'h0, "x_runf_pre");
      drive(4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
      exp_now(K_PC, 16'h2, "x_ret_pc1"); exp_now(K_RUNF, RAS ? 16'h1 : 16'h0, "x_runf_post");

      drive(4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
      drive(4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
